// File: rtl/dm_port_arbiter.sv
// Shared data-memory sequencer: arbitrates CPU load/store against a word-wide aux port,
// builds byte lanes for sub-word stores and runs the req/ready handshake to the memory.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_exc,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_done,
  output logic [31:0] aux_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        grant_aux_reg, grant_aux_next;
  logic        exc_reg, exc_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [31:0] cpu_rdata_reg, cpu_rdata_next;
  logic [31:0] aux_rdata_reg, aux_rdata_next;

  logic        cpu_size_bad;
  logic        cpu_misaligned;
  logic        cpu_fault;
  logic [3:0]  cpu_lane_be;
  logic [31:0] cpu_lane_wdata;
  logic        aux_forced;
  logic        grant_cpu;
  logic        grant_aux;
  logic        aux_addr_unused;

  // The aux port is word-only; its byte offset carries no information.
  assign aux_addr_unused = ^aux_addr[1:0];

  assign cpu_size_bad   = (cpu_size == 2'b11);
  assign cpu_misaligned = ((cpu_size == SIZE_HALF) && cpu_addr[0]) ||
                          ((cpu_size == SIZE_WORD) && (cpu_addr[1:0] != 2'b00));
  assign cpu_fault      = cpu_size_bad | cpu_misaligned;

  // Per-lane enable and data select for the CPU store path.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign cpu_lane_be[gi] =
          (cpu_size == SIZE_BYTE) ? (cpu_addr[1:0] == 2'(gi)) :
          (cpu_size == SIZE_HALF) ? (cpu_addr[1] == 1'(gi / 2)) :
                                    1'b1;
      assign cpu_lane_wdata[8*gi +: 8] =
          (cpu_size == SIZE_BYTE) ? cpu_wdata[7:0] :
          (cpu_size == SIZE_HALF) ? cpu_wdata[8*(gi % 2) +: 8] :
                                    cpu_wdata[8*gi +: 8];
    end
  endgenerate

  assign aux_forced = aux_req && (starve_cnt_reg == STARVE_MAX);
  assign grant_cpu  = cpu_req && !aux_forced;
  assign grant_aux  = aux_req && !grant_cpu;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    grant_aux_next  = grant_aux_reg;
    exc_next        = exc_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_be_next     = mem_be_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cpu_rdata_next  = cpu_rdata_reg;
    aux_rdata_next  = aux_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (grant_cpu) begin
          grant_aux_next = 1'b0;
          if (!aux_req) begin
            starve_cnt_next = 4'd0;
          end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
          if (cpu_fault) begin
            // Faulting accesses never reach the memory.
            exc_next       = 1'b1;
            cpu_rdata_next = 32'h0;
            state_next     = ST_RESP;
          end else begin
            exc_next       = 1'b0;
            mem_req_next   = 1'b1;
            mem_we_next    = cpu_we;
            mem_be_next    = cpu_we ? cpu_lane_be : 4'b1111;
            mem_addr_next  = {cpu_addr[31:2], 2'b00};
            mem_wdata_next = cpu_lane_wdata;
            state_next     = ST_BUSY;
          end
        end else if (grant_aux) begin
          grant_aux_next  = 1'b1;
          starve_cnt_next = 4'd0;
          exc_next        = 1'b0;
          mem_req_next    = 1'b1;
          mem_we_next     = aux_we;
          mem_be_next     = 4'b1111;
          mem_addr_next   = {aux_addr[31:2], 2'b00};
          mem_wdata_next  = aux_wdata;
          state_next      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (grant_aux_reg) begin
            aux_rdata_next = mem_rdata;
          end else begin
            cpu_rdata_next = mem_rdata;
          end
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= 4'd0;
      grant_aux_reg  <= 1'b0;
      exc_reg        <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= 4'b0000;
      mem_addr_reg   <= 32'h0;
      mem_wdata_reg  <= 32'h0;
      cpu_rdata_reg  <= 32'h0;
      aux_rdata_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      grant_aux_reg  <= grant_aux_next;
      exc_reg        <= exc_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_be_reg     <= mem_be_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      aux_rdata_reg  <= aux_rdata_next;
    end
  end

  assign cpu_done  = (state_reg == ST_RESP) && !grant_aux_reg;
  assign aux_done  = (state_reg == ST_RESP) && grant_aux_reg;
  assign cpu_exc   = cpu_done && exc_reg;
  assign cpu_stall = cpu_req && !cpu_done;
  assign cpu_rdata = cpu_rdata_reg;
  assign aux_rdata = aux_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_dm_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_done, cpu_exc;
  logic [31:0] cpu_rdata;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [31:0] aux_addr = '0, aux_wdata = '0;
  logic        aux_done;
  logic [31:0] aux_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_exc(cpu_exc),
    .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_done(aux_done), .aux_rdata(aux_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ready after a chosen number of wait cycles, optional stray ready when idle.
  int          fixed_lat = 0;
  bit          spurious_en = 1'b0;
  bit          rdata_fixed_en = 1'b0;
  logic [31:0] rdata_fixed = '0;
  int          rsp_cnt = 0;
  int          rsp_lat = 0;

  initial begin : responder
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (rsp_cnt == 0) rsp_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        if (rsp_cnt == rsp_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rdata_fixed_en ? rdata_fixed : $urandom;
          rsp_cnt   = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          rsp_cnt++;
        end
      end else begin
        rsp_cnt   = 0;
        mem_ready = spurious_en && ($urandom_range(0, 2) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Transaction-level model: one access in flight, then a response cycle.
  bit          m_busy = 1'b0, m_resp = 1'b0, m_port_aux = 1'b0, m_exc = 1'b0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_cpu_rdata = '0, m_aux_rdata = '0;

  initial begin : compare
    bit e_cdone, e_adone;
    int nb;
    forever begin
      @(negedge clk);
      e_cdone = m_resp && !m_port_aux;
      e_adone = m_resp && m_port_aux;
      check("mem_req",   32'(mem_req),   32'(m_busy));
      check("cpu_done",  32'(cpu_done),  32'(e_cdone));
      check("aux_done",  32'(aux_done),  32'(e_adone));
      check("cpu_exc",   32'(cpu_exc),   32'(e_cdone && m_exc));
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cdone));
      check("cpu_rdata", cpu_rdata, m_cpu_rdata);
      check("aux_rdata", aux_rdata, m_aux_rdata);
      if (m_busy) begin
        check("mem_we",   32'(mem_we), 32'(m_we));
        check("mem_be",   32'(mem_be), 32'(m_be));
        check("mem_addr", mem_addr, m_addr);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end

      if (reset) begin
        m_busy = 1'b0; m_resp = 1'b0; m_exc = 1'b0; m_starve = 0;
        m_cpu_rdata = '0; m_aux_rdata = '0;
      end else if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_busy) begin
        if (mem_ready) begin
          if (m_port_aux) m_aux_rdata = mem_rdata;
          else            m_cpu_rdata = mem_rdata;
          m_busy = 1'b0;
          m_resp = 1'b1;
        end
      end else if (cpu_req && !(aux_req && m_starve == LIMIT)) begin
        m_port_aux = 1'b0;
        m_starve   = aux_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        nb         = 1 << cpu_size;
        if (cpu_size == 2'b11 || (cpu_addr % 32'(nb)) != 0) begin
          m_exc = 1'b1; m_resp = 1'b1; m_cpu_rdata = '0;
        end else begin
          m_exc  = 1'b0;
          m_busy = 1'b1;
          m_we   = cpu_we;
          m_addr = cpu_addr & ~32'h3;
          m_be   = cpu_we ? 4'(((32'd1 << nb) - 32'd1) << (cpu_addr % 4)) : 4'hF;
          m_wdata = (cpu_size == 2'b00) ? (cpu_wdata & 32'hFF) * 32'h01010101 :
                    (cpu_size == 2'b01) ? (cpu_wdata & 32'hFFFF) * 32'h00010001 : cpu_wdata;
        end
      end else if (aux_req) begin
        m_port_aux = 1'b1;
        m_starve   = 0;
        m_exc      = 1'b0;
        m_busy     = 1'b1;
        m_we       = aux_we;
        m_addr     = aux_addr & ~32'h3;
        m_be       = 4'hF;
        m_wdata    = aux_wdata;
      end
    end
  end

  // One CPU access from an IDLE cycle; reports what the memory side and CPU side showed.
  task automatic cpu_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int done_cyc, output int stall_n,
                         output int req_n, output int unstable_n, output logic [3:0] be_s,
                         output logic [31:0] addr_s, output logic [31:0] wdata_s,
                         output logic we_s, output logic exc_s, output logic [31:0] rdata_s);
    bit seen = 1'b0;
    done_cyc = -1; stall_n = 0; req_n = 0; unstable_n = 0;
    be_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0; exc_s = 1'b0; rdata_s = '0;
    cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (mem_req) begin
        if (!seen) begin
          be_s = mem_be; addr_s = mem_addr; wdata_s = mem_wdata; we_s = mem_we; seen = 1'b1;
        end else if ({mem_be, mem_addr, mem_wdata, mem_we} !== {be_s, addr_s, wdata_s, we_s}) begin
          unstable_n++;
        end
        req_n++;
      end
      if (cpu_done) begin
        done_cyc = c; exc_s = cpu_exc; rdata_s = cpu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          dc, sn, rn, un, n_seen, dn;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wdata_s, rdata_s;
    logic        we_s, exc_s, cd, ad;
    logic [9:0]  seq_bits;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   32'(mem_req),  32'h0);
    check("rst_mem_we",    32'(mem_we),   32'h0);
    check("rst_mem_be",    32'(mem_be),   32'h0);
    check("rst_mem_addr",  mem_addr,      32'h0);
    check("rst_mem_wdata", mem_wdata,     32'h0);
    check("rst_cpu_done",  32'(cpu_done), 32'h0);
    check("rst_aux_done",  32'(aux_done), 32'h0);
    check("rst_cpu_exc",   32'(cpu_exc),  32'h0);
    check("rst_cpu_rdata", cpu_rdata,     32'h0);
    check("rst_aux_rdata", aux_rdata,     32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    fixed_lat = 0; rdata_fixed_en = 1'b1; rdata_fixed = 32'hDEADBEEF;
    cpu_txn(1'b0, 2'b10, 32'h0000_0010, 32'h0, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("lw_addr", addr_s, 32'h10);
    check("lw_be", 32'(be_s), 32'hF);
    check("lw_we", 32'(we_s), 32'h0);
    check("lw_done_cycle", 32'(dc), 32'd2);
    check("lw_rdata", rdata_s, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(sn), 32'd2);
    rdata_fixed_en = 1'b0;

    cpu_txn(1'b1, 2'b00, 32'h0000_0013, 32'h0000_00A5, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("sb_be", 32'(be_s), 32'h8);
    check("sb_wdata", wdata_s, 32'hA5A5A5A5);
    check("sb_addr", addr_s, 32'h10);
    check("sb_we", 32'(we_s), 32'h1);

    cpu_txn(1'b1, 2'b01, 32'h0000_0012, 32'h0000_1234, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("sh_be", 32'(be_s), 32'hC);
    check("sh_wdata", wdata_s, 32'h12341234);
    check("sh_addr", addr_s, 32'h10);

    cpu_txn(1'b0, 2'b10, 32'h0000_0006, 32'h0, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("exc_flag", 32'(exc_s), 32'h1);
    check("exc_done_cycle", 32'(dc), 32'd1);
    check("exc_mem_req_cycles", 32'(rn), 32'd0);
    check("exc_rdata", rdata_s, 32'h0);

    // Both ports request continuously; record completion order (1 = aux).
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h20;
    aux_we = 1'b0; aux_addr = 32'h40;
    cpu_req = 1'b1; aux_req = 1'b1;
    seq_bits = '0; n_seen = 0;
    for (int c = 0; c < 100 && n_seen < 10; c++) begin
      @(negedge clk);
      if (cpu_done || aux_done) begin
        seq_bits = {seq_bits[8:0], aux_done};
        n_seen++;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    check("starve_count", 32'(n_seen), 32'd10);
    check("starve_order", 32'(seq_bits), 32'(10'b0000100001));

    fixed_lat = 5;
    cpu_txn(1'b1, 2'b10, 32'h0000_0024, 32'hCAFEF00D, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("slow_done_cycle", 32'(dc), 32'd7);
    check("slow_req_cycles", 32'(rn), 32'd6);
    check("slow_unstable", 32'(un), 32'd0);
    check("slow_wdata", wdata_s, 32'hCAFEF00D);
    check("slow_be", 32'(be_s), 32'hF);

    // Abandon an access with reset in its third wait cycle.
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h30; cpu_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy_before", 32'(mem_req), 32'h1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'h0);
    dn = (cpu_done || aux_done) ? 1 : 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_done || aux_done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    @(posedge clk); #1;
    fixed_lat = 0;
    cpu_txn(1'b0, 2'b10, 32'h0000_0030, 32'h0, dc, sn, rn, un, be_s, addr_s, wdata_s, we_s, exc_s, rdata_s);
    check("abort_restart_cycle", 32'(dc), 32'd2);

    // Random traffic, variable latency, stray ready pulses and occasional reset.
    fixed_lat = -1; spurious_en = 1'b1;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      cd = cpu_done; ad = aux_done;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      if (!cpu_req || cd) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        cpu_addr  = $urandom;
        if ($urandom_range(0, 1) == 1) cpu_addr[1:0] = 2'b00;
        cpu_wdata = $urandom;
      end
      if (!aux_req || ad) begin
        aux_req   = ($urandom_range(0, 1) == 1);
        aux_we    = 1'($urandom_range(0, 1));
        aux_addr  = $urandom;
        aux_wdata = $urandom;
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; aux_req = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
